// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_DEFAULT = 5;
    localparam int unsigned SEL_W       = 4;

    // ceil(n/2): number of high cycles in one output period
    function automatic int unsigned high_len(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] div_in,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);

    localparam logic [W-1:0] DefDiv = W'(DEFAULT_DIV);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_q, n_d;
    logic [W-1:0] p_q, p_d;
    logic         pend_q, pend_d;
    logic         en_q;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;

    logic start, short_div, at_end, boundary, apply;

    always_comb begin
        start     = en && !en_q;
        short_div = n_q < W'(2);
        at_end    = cnt_q == n_q - W'(1);
        // Any edge that begins a fresh period may swap in the pending divisor
        boundary  = !en || short_div || start || at_end;
        apply     = pend_q && boundary;

        n_d    = apply ? p_q : n_q;
        cnt_d  = boundary ? '0 : cnt_q + W'(1);
        p_d    = wr ? div_in : p_q;
        pend_d = wr ? 1'b1 : (apply ? 1'b0 : pend_q);

        clk_out_d = en && (n_d >= W'(2)) && (cnt_d < W'(high_len(32'(n_d))));
        tick_d    = en && (n_d != '0) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            n_q       <= DefDiv;
            p_q       <= DefDiv;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            p_q       <= p_d;
            pend_q    <= pend_d;
            en_q      <= en;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider sharing a single divisor write port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned W           = 16,
    parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [W-1:0]     div_in,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    pend
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic wr;
        // Selects at or above CH match no channel and are dropped
        assign wr = div_wr && (div_sel == SEL_W'(i));

        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr      (wr),
            .div_in  (div_in),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi against a time-based reference model.
module tb_clk_div_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] en = '0;
    logic          div_wr = 1'b0;
    logic [3:0]    div_sel = '0;
    logic [W-1:0]  div_in = '0;
    logic [CH-1:0] clk_out, tick, pend;

    clk_div_multi #(.CH(CH), .W(W), .DEFAULT_DIV(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_in  (div_in),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] t;
        logic [CH-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: each channel's output is a function of elapsed edges since its period
    // start; divisor swaps move the period start.
    int unsigned t_edge;
    int unsigned m_n[CH], m_p[CH], m_start[CH];
    bit          m_pend[CH], m_run[CH];

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            t_edge = 0;
            for (int c = 0; c < CH; c++) begin
                m_n[c] = 5; m_p[c] = 5; m_start[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            end
            exp_q.delete();
        end else begin
            exp_t e;
            t_edge++;
            e = '0;
            for (int c = 0; c < CH; c++) begin
                int unsigned ph;
                if (!en[c]) begin
                    if (m_pend[c]) begin m_n[c] = m_p[c]; m_pend[c] = 0; end
                    m_run[c] = 0;
                end else begin
                    if (!m_run[c] || m_n[c] < 2) begin
                        if (m_pend[c]) begin m_n[c] = m_p[c]; m_pend[c] = 0; end
                        m_start[c] = t_edge;
                    end else if ((t_edge - m_start[c]) % m_n[c] == 0 && m_pend[c]) begin
                        m_n[c] = m_p[c]; m_pend[c] = 0; m_start[c] = t_edge;
                    end
                    m_run[c] = 1;
                    ph = (m_n[c] >= 2) ? (t_edge - m_start[c]) % m_n[c] : 0;
                    e.c[c] = (m_n[c] >= 2) && (ph < m_n[c] - m_n[c] / 2);
                    e.t[c] = (m_n[c] >= 1) && (ph == 0);
                end
                if (div_wr && div_sel == 4'(c)) begin
                    m_p[c] = 32'(div_in); m_pend[c] = 1;
                end
                e.p[c] = m_pend[c];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every post-reset edge must present exactly the expected output vector
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard: no expectation queued at time %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (clk_out !== e.c || tick !== e.t || pend !== e.p) begin
                    n_errors++;
                    $display("FAIL outputs edge %0d: got clk_out=%b tick=%b pend=%b, want %b %b %b",
                             t_edge, clk_out, tick, pend, e.c, e.t, e.p);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_checks++;
        if (clk_out !== '0 || tick !== '0 || pend !== '0) begin
            n_errors++;
            $display("FAIL %s: got clk_out=%b tick=%b pend=%b, want all 0",
                     name, clk_out, tick, pend);
        end
    endtask

    // Caller is positioned just after a falling edge; the write is sampled on the next edge
    task automatic write_div(input int unsigned sel, input int unsigned val);
        div_wr  = 1'b1;
        div_sel = 4'(sel);
        div_in  = W'(val);
        @(negedge clk);
        div_wr  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ch, input int unsigned ph);
        bit found;
        found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (m_n[ch] >= 2 && (t_edge - m_start[ch]) % m_n[ch] == ph) found = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL wait_phase ch%0d: phase %0d not reached, want reached", ch, ph);
        end
    endtask

    initial begin
        run(3);
        check_zero("reset state");

        // Default divisor after release
        rst = 1'b1;
        en  = 4'b0001;
        run(20);

        // Mid-period change to 8
        wait_phase(0, 1);
        write_div(0, 8);
        run(24);

        // Edge divisors and out-of-range select
        write_div(0, 2); run(12);
        write_div(0, 1); run(6);
        write_div(0, 0); run(6);
        write_div(4, 9); run(4);

        // Write colliding with the wrap
        write_div(0, 5); run(3);
        write_div(0, 6);
        wait_phase(0, 4);
        write_div(0, 3);
        run(16);

        // Enable drop on channel 1
        en = 4'b0011;
        run(7);
        en = 4'b0001;
        run(4);
        en = 4'b0011;
        run(10);

        // Asynchronous reset between edges
        #3 rst = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk);
        check_zero("held in reset");
        rst = 1'b1;
        en  = 4'b1111;
        run(12);

        // Channel independence over one LCM period
        en = '0;
        write_div(0, 2);
        write_div(1, 3);
        write_div(2, 4);
        write_div(3, 7);
        run(1);
        en = 4'b1111;
        run(90);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            if ($urandom_range(0, 3) == 0) write_div($urandom_range(0, 5), $urandom_range(0, 9));
            else @(negedge clk);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider. Each of `CH` independent channels divides `clk` by a per-channel integer divisor `N` and produces a near-50%-duty divided clock, a one-cycle phase tick, and a pending-update flag. Divisor changes are glitch-free: they apply only at a period boundary. The block sits beside the system clock source and feeds slow-clock consumers such as display scan, debounce, and CPU single-step logic.

## Interface
- `CH`, 4: number of channels, 1..16.
- `W`, 16: divisor and counter width in bits.
- `DEFAULT_DIV`, 5: divisor loaded into every channel at reset; must be < 2^W.
- `clk` input, 1 bit: the only clock; all logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, `CH` bits: per-channel run enable.
- `div_wr` input, 1 bit: divisor write strobe, sampled each cycle.
- `div_sel` input, 4 bits: target channel for the write; values ≥ `CH` are ignored.
- `div_in` input, `W` bits: new divisor value.
- `clk_out` output, `CH` bits: divided clock, registered.
- `tick` output, `CH` bits: one-cycle pulse marking the first cycle of each output period, registered.
- `pend` output, `CH` bits: high while a written divisor is waiting to take effect.

## Operation
- Per-channel state:
  - `cnt` (W bits), active divisor `N`, pending divisor `P`.
  - `pend` flag, `clk_out` and `tick` registers.
- Defining `H = N - (N >> 1)` (ceil(N/2)): for N ≥ 2, `cnt` runs 0..N-1 and wraps. At each edge, `clk_out <= (cnt_next < H)` and `tick <= (cnt_next == 0)`. The output is high for ceil(N/2) cycles and low for floor(N/2) cycles.
- Wrap rule: when `cnt == N-1` at an edge, `cnt_next = 0`. If `pend` is set at that edge, `N <= P` and `pend <= 0`, and the new period's H is computed from the new N.
- N == 1: `tick` is 1 every cycle, `clk_out` is held 0, and a pending update applies at the next edge.
- N == 0: the channel is stopped. `cnt` holds 0, `clk_out` and `tick` are 0, and a pending update applies at the next edge.
- `en[i]` low:
  - `cnt <= 0`, `clk_out <= 0`, `tick <= 0`.
  - A pending update applies at the next edge.
  - On `en` rising, the first enabled edge gives `cnt = 0`, `clk_out = 1` (N ≥ 2) and `tick = 1`, so each enable starts a fresh period.
- Write: on `div_wr && div_sel < CH`, `P[div_sel] <= div_in` and `pend[div_sel] <= 1`.
  - A write while already pending overwrites P (last write wins).
  - A write in the same edge as a wrap leaves the wrap using the old P. The new value stays pending until the next wrap.
- Channels are fully independent; one write port serves all channels.

## Timing
- Reset (asynchronous, immediate): `cnt = 0`, `N = DEFAULT_DIV`, `P = DEFAULT_DIV`, `pend = 0`, `clk_out = 0`, `tick = 0` on all channels.
- Reset deassertion is synchronised by the user. The first edge after release with `en` high behaves as an enable rising edge.
- Write-to-pend latency: 1 edge.
- Pend-to-apply latency: at most N edges (the next wrap), or 1 edge if the channel is disabled or has N < 2.
- `clk_out` and `tick` are registered and therefore glitch-free. `clk_out` is a data signal; consumers use it as a clock only through a clock buffer, per board rules.
- Reset asserted mid-period aborts the period with no partial pulse beyond the reset edge.

## Structure
- Package `clk_div_pkg` holds:
  - the `DEFAULT_DIV` default and the `SEL_W = 4` constant;
  - a function `high_len(N)` returning ceil(N/2).
- Sub-module `clk_div_chan` holds one channel: counter, N/P registers, pend flag, output registers.
- The top level decodes `div_sel` into per-channel write enables and generates `CH` instances.
- Expected size is about 150–250 lines total.

## Test plan
- **Reset default:** release `rst` with `en = 1` on channel 0 and hold it 20 cycles. Expect `clk_out[0]` pattern 1,1,1,0,0 repeating (period 5), and `tick[0]` high on cycles 1, 6, 11, 16.
- **Mid-period change:**
  - Channel 0 at N = 5: write `div_in = 8` at cnt = 1. Expect `pend[0]` = 1 for the next 3 edges, then the new period starts.
  - New pattern is 4 high, 4 low; `pend[0]` returns to 0 on the wrap edge.
- **Edge divisors and out-of-range select:**
  - N = 2: `clk_out` toggles every cycle.
  - N = 1: `tick` = 1 every cycle and `clk_out` = 0.
  - N = 0: `clk_out` and `tick` stay 0.
  - A write with `div_sel = CH` changes no channel and asserts no `pend`.
- **Write colliding with wrap:**
  - Set up P = 6 pending, then write 3 exactly on the wrap edge. Expect the period that starts at that edge to be 6 cycles, with `pend` still 1.
  - The following period is 3 cycles.
- **Enable and reset mid-operation:**
  - Drop `en[1]` mid-period for 4 cycles: outputs go 0. On re-enable, expect `tick[1]` on the first edge.
  - Assert `rst` asynchronously between edges: all outputs drop to 0 immediately and divisors return to 5.
- **Channel independence:** set channels 0..3 to 2, 3, 4, 7 and run 84 cycles (LCM). Expect each period exact and all `tick` outputs coinciding at cycles 1 and 85.
